// File: rtl/lcd_interval_timer_if.sv
// lcd_interval_timer_if
//   Control/status bundle between an LCD sequencing FSM (master) and one
//   lcd_interval_timer instance (slave).
//   master drives : start, abort, enable, periodic, load_val, prescale
//   slave drives  : busy, done, count
//   CNT_W sets the width of load_val/count, PRE_W the width of prescale.
interface lcd_interval_timer_if #(
    parameter int CNT_W = 26,
    parameter int PRE_W = 8
);
    logic             start;
    logic             abort;
    logic             enable;
    logic             periodic;
    logic [CNT_W-1:0] load_val;
    logic [PRE_W-1:0] prescale;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;

    modport master (
        output start, abort, enable, periodic, load_val, prescale,
        input  busy, done, count
    );

    modport slave (
        input  start, abort, enable, periodic, load_val, prescale,
        output busy, done, count
    );
endinterface

// File: rtl/lcd_interval_timer.sv
// lcd_interval_timer
//   Programmable interval timer for LCD power-up waits, command delays and
//   refresh periods. One-shot or auto-reload, with a clock prescaler.
//   Period = (load_val+1)*(prescale+1) enabled clocks.
// Ports
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : lcd_interval_timer_if.slave
//           start    - one-cycle request: latch load_val/prescale/periodic, (re)start
//           abort    - stop at once, back to IDLE, no done (beats start)
//           enable   - 0 pauses prescaler and count
//           periodic - 0 one-shot, 1 auto-reload (latched at start)
//           load_val - terminal count TC
//           prescale - tick divider minus one
//           busy     - 1 while running
//           done     - one-cycle pulse when count wraps TC -> 0
//           count    - current count, 0..TC
module lcd_interval_timer #(
    parameter int CNT_W = 26,
    parameter int PRE_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    lcd_interval_timer_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;   // running prescaler
    logic [CNT_W-1:0] tc_q,      tc_d;        // latched terminal count
    logic [PRE_W-1:0] pre_q,     pre_d;       // latched prescale value
    logic             mode_q,    mode_d;      // latched periodic flag
    logic             done_q,    done_d;

    // NOTE: every variable gets its hold/default value first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pre_cnt_d = pre_cnt_q;
        tc_d      = tc_q;
        pre_d     = pre_q;
        mode_d    = mode_q;
        done_d    = 1'b0;

        if (bus.abort) begin
            // abort outranks start: a simultaneous start is dropped
            state_d   = IDLE;
            count_d   = '0;
            pre_cnt_d = '0;
        end else if (bus.start) begin
            // identical reload from IDLE or RUN; a restart emits no done
            state_d   = RUN;
            count_d   = '0;
            pre_cnt_d = '0;
            tc_d      = bus.load_val;
            pre_d     = bus.prescale;
            mode_d    = bus.periodic;
        end else if (state_q == RUN && bus.enable) begin
            if (pre_cnt_q == pre_q) begin
                pre_cnt_d = '0;
                if (count_q == tc_q) begin
                    // explicit compare against TC, so TC = all-ones wraps to
                    // 0 on the same edge as the natural overflow would
                    count_d = '0;
                    done_d  = 1'b1;
                    if (!mode_q) begin
                        state_d = IDLE;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pre_cnt_q <= '0;
            tc_q      <= '0;
            pre_q     <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pre_cnt_q <= pre_cnt_d;
            tc_q      <= tc_d;
            pre_q     <= pre_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
        end
    end

    // busy is a direct decode of the one-bit state flop, so it stays glitch-free
    // and falls on the same edge that raises a one-shot done
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.count = count_q;

endmodule

// File: tb/tb_lcd_interval_timer.sv
// tb_lcd_interval_timer
//   Directed bench for lcd_interval_timer: a table of single-cycle vectors
//   with hand-computed outputs, plus hand-written multi-cycle sequences for
//   prescaled periodic runs, pause, asynchronous reset and a 4-bit wrap.
module tb_lcd_interval_timer;

    localparam int CNT_W = 26;
    localparam int PRE_W = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lcd_interval_timer_if #(.CNT_W(CNT_W), .PRE_W(PRE_W)) bus ();
    lcd_interval_timer_if #(.CNT_W(4),     .PRE_W(2))     bus4 ();

    lcd_interval_timer #(.CNT_W(CNT_W), .PRE_W(PRE_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    lcd_interval_timer #(.CNT_W(4), .PRE_W(2)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    typedef struct {
        string            name;
        logic             start;
        logic             abort;
        logic             enable;
        logic             periodic;
        logic [CNT_W-1:0] load_val;
        logic [PRE_W-1:0] prescale;
        logic             exp_busy;
        logic             exp_done;
        logic [CNT_W-1:0] exp_count;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input bit s, input bit a, input bit en,
                                input bit per, input int ld, input int pre,
                                input bit b, input bit d, input int c);
        vec_t v;
        v.name      = name;
        v.start     = s;
        v.abort     = a;
        v.enable    = en;
        v.periodic  = per;
        v.load_val  = CNT_W'(ld);
        v.prescale  = PRE_W'(pre);
        v.exp_busy  = b;
        v.exp_done  = d;
        v.exp_count = CNT_W'(c);
        vecs.push_back(v);
    endfunction

    task automatic drive(input bit s, input bit a, input bit en, input bit per,
                         input int ld, input int pre);
        bus.start    = s;
        bus.abort    = a;
        bus.enable   = en;
        bus.periodic = per;
        bus.load_val = CNT_W'(ld);
        bus.prescale = PRE_W'(pre);
    endtask

    // one rising edge, then settle; outputs read here reflect that edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input bit b, input bit d, input int c);
        check({name, ".busy"},  32'(bus.busy),  32'(b));
        check({name, ".done"},  32'(bus.done),  32'(d));
        check({name, ".count"}, 32'(bus.count), 32'(c));
    endtask

    initial begin
        int  cycles;
        bit  seen;

        // ---------------- vector table ----------------
        // one-shot, TC=4: done 5 clocks after start, busy falls with it
        add("os_start", 1,0,1,0, 4,0, 1,0,0);
        for (int i = 1; i <= 4; i++) add("os_cnt", 0,0,1,0, 4,0, 1,0,i);
        add("os_done",  0,0,1,0, 4,0, 0,1,0);
        add("os_idle",  0,0,1,0, 4,0, 0,0,0);
        // inputs changing mid-run are ignored (still TC=3, one-shot, no prescale)
        add("ign_start", 1,0,1,0, 3,0, 1,0,0);
        for (int i = 1; i <= 3; i++) add("ign_cnt", 0,0,1,1, 9,5, 1,0,i);
        add("ign_done",  0,0,1,1, 9,5, 0,1,0);
        add("ign_idle",  0,0,1,1, 9,5, 0,0,0);
        // abort at count=6: IDLE, no done afterwards
        add("ab_start", 1,0,1,0, 9,0, 1,0,0);
        for (int i = 1; i <= 6; i++) add("ab_cnt", 0,0,1,0, 9,0, 1,0,i);
        add("abort",    0,1,1,0, 9,0, 0,0,0);
        for (int i = 0; i < 3; i++) add("ab_idle", 0,0,1,0, 9,0, 0,0,0);
        // abort together with start while running -> IDLE
        add("as_start", 1,0,1,0, 9,0, 1,0,0);
        add("as_cnt",   0,0,1,0, 9,0, 1,0,1);
        add("as_both",  1,1,1,0, 9,0, 0,0,0);
        add("as_idle",  0,0,1,0, 9,0, 0,0,0);
        // restart at count=6 with load_val=2: done 3 clocks later
        add("rs_start", 1,0,1,0, 9,0, 1,0,0);
        for (int i = 1; i <= 6; i++) add("rs_cnt", 0,0,1,0, 9,0, 1,0,i);
        add("restart",  1,0,1,0, 2,0, 1,0,0);
        add("rs_c1",    0,0,1,0, 2,0, 1,0,1);
        add("rs_c2",    0,0,1,0, 2,0, 1,0,2);
        add("rs_done",  0,0,1,0, 2,0, 0,1,0);
        // start during the done cycle of a periodic run: reload wins
        add("pd_start", 1,0,1,1, 1,0, 1,0,0);
        add("pd_c1",    0,0,1,1, 1,0, 1,0,1);
        add("pd_done",  0,0,1,1, 1,0, 1,1,0);
        add("pd_reld",  1,0,1,1, 3,0, 1,0,0);
        add("pd_c1b",   0,0,1,1, 3,0, 1,0,1);
        add("pd_abort", 0,1,1,1, 3,0, 0,0,0);
        // TC=0 periodic, no prescale: done every clock
        add("z_start",  1,0,1,1, 0,0, 1,0,0);
        for (int i = 0; i < 4; i++) add("z_done", 0,0,1,1, 0,0, 1,1,0);
        add("z_abort",  0,1,1,1, 0,0, 0,0,0);

        // ---------------- reset ----------------
        drive(0,0,1,0, 0,0);
        bus4.start = 1'b0; bus4.abort = 1'b0; bus4.enable = 1'b1;
        bus4.periodic = 1'b0; bus4.load_val = '0; bus4.prescale = '0;
        reset = 1'b1;
        #12;
        check_out("reset", 0,0,0);
        check("reset4.busy", 32'(bus4.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_out("post_reset", 0,0,0);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].abort, vecs[i].enable, vecs[i].periodic,
                  int'(vecs[i].load_val), int'(vecs[i].prescale));
            step();
            check_out(vecs[i].name, vecs[i].exp_busy, vecs[i].exp_done, int'(vecs[i].exp_count));
        end
        drive(0,0,1,0, 0,0);

        // ---------------- periodic with prescale ----------------
        // TC=2, prescale=3: count steps every 4 clocks, done every 12
        drive(1,0,1,1, 2,3);
        step();
        check_out("pp_start", 1,0,0);
        drive(0,0,1,1, 2,3);
        for (int n = 1; n <= 36; n++) begin
            step();
            check_out("pp_run", 1, (n % 12 == 0), (n / 4) % 3);
        end
        drive(0,1,1,1, 2,3);
        step();
        check_out("pp_abort", 0,0,0);

        // ---------------- pause ----------------
        // one-shot TC=10: done normally at edge 11; 7-clock pause -> edge 18
        drive(1,0,1,0, 10,0);
        step();
        check_out("pa_start", 1,0,0);
        drive(0,0,1,0, 10,0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("pa_cnt", 32'(bus.count), 32'(k));
        end
        bus.enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            check_out("pa_hold", 1,0,3);
        end
        bus.enable = 1'b1;
        cycles = 10;
        seen   = 1'b0;
        while (!seen && cycles < 40) begin
            step();
            cycles++;
            seen = bus.done;
        end
        check("pa_done_seen", 32'(seen), 32'd1);
        check("pa_done_cycle", 32'(cycles), 32'd18);
        check("pa_busy_fall", 32'(bus.busy), 32'd0);
        drive(0,0,1,0, 0,0);
        step();

        // ---------------- asynchronous reset mid-run ----------------
        drive(1,0,1,0, 20,0);
        step();
        drive(0,0,1,0, 20,0);
        for (int k = 0; k < 5; k++) step();
        check("rst_pre.count", 32'(bus.count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check_out("rst_async", 0,0,0);
        step();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_out("rst_after", 0,0,0);
        end

        // ---------------- CNT_W=4, TC=15 wrap ----------------
        bus4.start = 1'b1; bus4.periodic = 1'b1; bus4.load_val = 4'd15;
        step();
        check("w4_start.count", 32'(bus4.count), 32'd0);
        bus4.start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            check("w4_cnt", 32'(bus4.count), 32'(k));
            check("w4_nodone", 32'(bus4.done), 32'd0);
        end
        step();
        check("w4_wrap.count", 32'(bus4.count), 32'd0);
        check("w4_wrap.done",  32'(bus4.done),  32'd1);
        check("w4_wrap.busy",  32'(bus4.busy),  32'd1);
        step();
        check("w4_next.count", 32'(bus4.count), 32'd1);
        check("w4_next.done",  32'(bus4.done),  32'd0);
        bus4.abort = 1'b1;
        step();
        bus4.abort = 1'b0;
        check("w4_abort.busy", 32'(bus4.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
